// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and default configuration for the instruction fetch stage.
`default_nettype none

package ifetch_pkg;

    localparam int                    IFETCH_INST_W       = 16;
    localparam int                    IFETCH_I_ADDR_W     = 12;
    localparam int                    IFETCH_DEPTH        = 2;
    localparam logic [IFETCH_I_ADDR_W-1:0] IFETCH_RESET_VECTOR = '0;

    typedef enum logic [0:0] {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [IFETCH_INST_W-1:0]   instruction;
        logic [IFETCH_I_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry in-order buffer of fetched instructions with flush; head is read from registers.
`default_nettype none

module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int  DEPTH   = IFETCH_DEPTH,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  entry_t                   push_data_i,
    input  logic                     pop_i,
    output entry_t                   head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            w_push;
    logic            w_pop;

    assign w_push = push_i & ~flush_i;
    assign w_pop  = pop_i & ~flush_i & (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) mem_q[wr_ptr_q] <= push_data_i;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Upstream credit accounting must never let a response arrive with every slot occupied.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && count_q == (PW+1)'(DEPTH)));

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// instruction_fetch: sequential fetch with credit-limited requests, in-order buffer and redirect flush.
// Optional IFETCH_PERF_CNT_EN adds saturating stall and redirect counters.
`default_nettype none

module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter int                  INST_W       = IFETCH_INST_W,
    parameter int                  I_ADDR_W     = IFETCH_I_ADDR_W,
    parameter int                  DEPTH        = IFETCH_DEPTH,
    parameter logic [I_ADDR_W-1:0] RESET_VECTOR = I_ADDR_W'(IFETCH_RESET_VECTOR)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_enable,
    input  logic                redirect_valid,
    input  logic [I_ADDR_W-1:0] redirect_addr,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [I_ADDR_W-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INST_W-1:0]   imem_rsp_data,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [INST_W-1:0]   instruction,
    output logic [I_ADDR_W-1:0] instr_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [15:0]         fetch_stall_cycles,
    output logic [15:0]         redirect_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INST_W-1:0]   instruction;
        logic [I_ADDR_W-1:0] pc;
    } entry_t;

    fetch_state_e        state_q, state_d;
    logic [I_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [I_ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]       outstanding_q, outstanding_d;
    logic [CW-1:0]       discard_q, discard_d;
    logic [CW-1:0]       w_count;
    logic [CW:0]         w_inflight;
    logic                w_req_fire, w_drop_rsp, w_push, w_pop;
    entry_t              w_head;

    assign w_inflight     = {1'b0, w_count} + {1'b0, outstanding_q};
    assign imem_req_valid = ~reset & fetch_enable & ~redirect_valid
                          & (w_inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign w_req_fire     = imem_req_valid & imem_req_ready;
    assign w_push         = imem_rsp_valid & ~redirect_valid & ~w_drop_rsp;
    assign w_pop          = instr_valid & instr_ready & ~redirect_valid;

    // Non-stale responses are always sequential from the last redirect target, so their pc is a counter.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(w_req_fire) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            fetch_pc_d = redirect_addr;
            rsp_pc_d   = redirect_addr;
            discard_d  = outstanding_q - CW'(imem_rsp_valid);
        end else begin
            if (w_req_fire) fetch_pc_d = fetch_pc_q + I_ADDR_W'(1);
            if (w_push)     rsp_pc_d   = rsp_pc_q + I_ADDR_W'(1);
            if (imem_rsp_valid && w_drop_rsp) discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_VECTOR;
            rsp_pc_q      <= RESET_VECTOR;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    always_comb begin
        state_d = (discard_d != '0) ? DISCARD : FETCH;
    end

    always_comb begin
        w_drop_rsp = (state_q == DISCARD);
    end

    ifetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect_valid),
        .push_i      (w_push),
        .push_data_i ('{instruction: imem_rsp_data, pc: rsp_pc_q}),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count)
    );

    assign instr_valid = (w_count != '0);
    assign instruction = w_head.instruction;
    assign instr_pc    = w_head.pc;

`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] stall_cnt_q, redirect_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (instr_ready && !instr_valid && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (redirect_valid && redirect_cnt_q != 16'hFFFF)
                redirect_cnt_q <= redirect_cnt_q + 16'd1;
        end
    end

    assign fetch_stall_cycles = stall_cnt_q;
    assign redirect_count     = redirect_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector table plus queue-based reference model with random stimulus.
`default_nettype none
`timescale 1ns/1ps

module tb_instruction_fetch;

    localparam int INST_W = 16;
    localparam int AW     = 12;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              fetch_enable = 1'b0, redirect_valid = 1'b0;
    logic [AW-1:0]     redirect_addr = '0;
    logic              imem_req_valid, imem_req_ready = 1'b0;
    logic [AW-1:0]     imem_req_addr;
    logic              imem_rsp_valid = 1'b0;
    logic [INST_W-1:0] imem_rsp_data = '0;
    logic              instr_valid, instr_ready = 1'b0;
    logic [INST_W-1:0] instruction;
    logic [AW-1:0]     instr_pc;
`ifdef IFETCH_PERF_CNT_EN
    logic [15:0]       fetch_stall_cycles, redirect_count;
`endif

    instruction_fetch #(.INST_W(INST_W), .I_ADDR_W(AW), .DEPTH(DEPTH), .RESET_VECTOR('0)) dut (
        .clk(clk), .reset(reset), .fetch_enable(fetch_enable),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc)
`ifdef IFETCH_PERF_CNT_EN
        , .fetch_stall_cycles(fetch_stall_cycles), .redirect_count(redirect_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; int due; bit stale; } req_t;
    typedef struct {
        bit fe, rr, rsp; logic [AW-1:0] rsp_addr; bit ir;
        bit e_rv; logic [AW-1:0] e_addr; bit e_iv; logic [AW-1:0] e_pc;
    } vec_t;

    req_t          infl[$];
    logic [AW-1:0] fifo_m[$];
    logic [AW-1:0] seen[$];
    logic [AW-1:0] m_pc = '0;
    int            cyc = 0, lat_min = 1, lat_max = 1;
    int            m_stalls = 0, m_redirs = 0, dut_fires = 0;
    int            errors = 0, checks = 0;
    vec_t          tbl[7];

    function automatic logic [INST_W-1:0] mem_word(input logic [AW-1:0] a);
        return {4'hA, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 0);
        chk({tag, "_req_addr"}, imem_req_addr, 0);
        chk({tag, "_instr_valid"}, instr_valid, 0);
        chk({tag, "_instruction"}, instruction, 0);
        chk({tag, "_instr_pc"}, instr_pc, 0);
`ifdef IFETCH_PERF_CNT_EN
        chk({tag, "_stall_cnt"}, fetch_stall_cycles, 0);
        chk({tag, "_redir_cnt"}, redirect_count, 0);
`endif
    endtask

    task automatic clear_model();
        infl.delete(); fifo_m.delete(); seen.delete();
        m_pc = '0; m_stalls = 0; m_redirs = 0;
    endtask

    task automatic idle_inputs();
        fetch_enable = 0; redirect_valid = 0; redirect_addr = '0; instr_ready = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; idle_inputs();
        #1 check_reset_outputs("rst");
        @(negedge clk);
        reset = 0;
        clear_model();
    endtask

    // Memory responds in order after a per-request latency; the model tracks buffered pcs and stale requests.
    task automatic step(input bit fe, input bit rd, input logic [AW-1:0] ra, input bit ir, input bit rr);
        bit   rsp, exp_rv;
        req_t e;
        @(negedge clk);
        rsp = (infl.size() > 0) && (infl[0].due <= cyc);
        fetch_enable = fe; redirect_valid = rd; redirect_addr = ra;
        instr_ready = ir; imem_req_ready = rr;
        imem_rsp_valid = rsp; imem_rsp_data = rsp ? mem_word(infl[0].addr) : '0;
        #1;
        exp_rv = fe && !rd && (fifo_m.size() + infl.size() < DEPTH);
        chk("req_valid", imem_req_valid, exp_rv);
        chk("req_addr", imem_req_addr, m_pc);
        chk("instr_valid", instr_valid, fifo_m.size() > 0);
        if (fifo_m.size() > 0) begin
            chk("instr_pc", instr_pc, fifo_m[0]);
            chk("instruction", instruction, mem_word(fifo_m[0]));
        end
`ifdef IFETCH_PERF_CNT_EN
        chk("stall_cnt", fetch_stall_cycles, m_stalls);
        chk("redir_cnt", redirect_count, m_redirs);
`endif
        if (instr_valid && ir && !rd) seen.push_back(instr_pc);
        if (imem_req_valid && rr) dut_fires++;
        if (ir && fifo_m.size() == 0) m_stalls++;
        if (rd) m_redirs++;
        if (!rd && ir && fifo_m.size() > 0) void'(fifo_m.pop_front());
        if (rsp) begin
            e = infl.pop_front();
            if (!rd && !e.stale) fifo_m.push_back(e.addr);
        end
        if (rd) begin
            fifo_m.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
            m_pc = ra;
        end else if (exp_rv && rr) begin
            e.addr  = m_pc;
            e.stale = 1'b0;
            e.due   = cyc + int'($urandom_range(lat_max, lat_min));
            if (infl.size() > 0 && infl[$].due >= e.due) e.due = infl[$].due + 1;
            infl.push_back(e);
            m_pc = m_pc + 1'b1;
        end
        cyc++;
    endtask

    task automatic wait_first_pc(input string name, input logic [AW-1:0] exp);
        seen.delete();
        for (int i = 0; i < 20 && seen.size() == 0; i++) step(1, 0, '0, 1, 1);
        if (seen.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: no instruction within 20 cycles, expected pc %0h", name, exp);
        end else chk(name, seen[0], exp);
    endtask

    initial begin
        tbl[0] = '{1, 1, 0, 12'h000, 1, 1, 12'h000, 0, 12'h000};
        tbl[1] = '{1, 1, 1, 12'h000, 1, 1, 12'h001, 0, 12'h000};
        tbl[2] = '{1, 1, 1, 12'h001, 1, 0, 12'h002, 1, 12'h000};
        tbl[3] = '{1, 1, 0, 12'h000, 1, 1, 12'h002, 1, 12'h001};
        tbl[4] = '{1, 1, 1, 12'h002, 1, 1, 12'h003, 0, 12'h000};
        tbl[5] = '{1, 1, 1, 12'h003, 1, 0, 12'h004, 1, 12'h002};
        tbl[6] = '{1, 1, 0, 12'h000, 1, 1, 12'h004, 1, 12'h003};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            fetch_enable = tbl[i].fe; imem_req_ready = tbl[i].rr; instr_ready = tbl[i].ir;
            redirect_valid = 0;
            imem_rsp_valid = tbl[i].rsp;
            imem_rsp_data  = tbl[i].rsp ? mem_word(tbl[i].rsp_addr) : '0;
            #1;
            chk("tbl_req_valid", imem_req_valid, tbl[i].e_rv);
            chk("tbl_req_addr", imem_req_addr, tbl[i].e_addr);
            chk("tbl_instr_valid", instr_valid, tbl[i].e_iv);
            if (tbl[i].e_iv) begin
                chk("tbl_instr_pc", instr_pc, tbl[i].e_pc);
                chk("tbl_instruction", instruction, mem_word(tbl[i].e_pc));
            end
        end

        // Back-pressure: only DEPTH requests, then resume without loss.
        do_reset();
        lat_min = 1; lat_max = 1; dut_fires = 0;
        for (int i = 0; i < 5; i++) step(1, 0, '0, 0, 1);
        chk("stall_req_count", dut_fires, DEPTH);
        seen.delete();
        for (int i = 0; i < 8; i++) step(1, 0, '0, 1, 1);
        if (seen.size() < 4) begin
            checks++; errors++;
            $display("FAIL resume_count: got %0d expected at least 4", seen.size());
        end else for (int i = 0; i < 4; i++) chk("resume_pc", seen[i], i);

        // Redirect with two stale requests in flight.
        lat_min = 3; lat_max = 3;
        step(1, 1, 12'h010, 1, 1);
        step(1, 0, '0, 1, 1);
        step(1, 0, '0, 1, 1);
        chk("two_outstanding", infl.size(), 2);
        step(1, 1, 12'h200, 1, 1);
        wait_first_pc("redirect_pc", 12'h200);

        // Address wrap.
        lat_min = 1; lat_max = 1;
        step(1, 1, 12'hFFE, 1, 1);
        seen.delete();
        for (int i = 0; i < 10; i++) step(1, 0, '0, 1, 1);
        if (seen.size() < 3) begin
            checks++; errors++;
            $display("FAIL wrap_count: got %0d expected at least 3", seen.size());
        end else begin
            chk("wrap_pc0", seen[0], 12'hFFE);
            chk("wrap_pc1", seen[1], 12'hFFF);
            chk("wrap_pc2", seen[2], 12'h000);
        end

        // Redirect coinciding with a handshake and a response.
        for (int i = 0; i < 20; i++) begin
            if (fifo_m.size() > 0 && infl.size() > 0 && infl[0].due <= cyc) break;
            step(1, 0, '0, 1, 1);
        end
        if (!(fifo_m.size() > 0 && infl.size() > 0 && infl[0].due <= cyc)) begin
            checks++; errors++;
            $display("FAIL collide_setup: condition not reached within 20 cycles");
        end
        step(1, 1, 12'h050, 1, 1);
        wait_first_pc("collide_pc", 12'h050);

        // Randomized traffic.
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            logic [AW-1:0] ra;
            ra = ($urandom_range(3, 0) == 0) ? 12'hFFC + AW'($urandom_range(3, 0)) : AW'($urandom);
            step($urandom_range(9, 0) != 0, $urandom_range(19, 0) == 0, ra,
                 $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
        end

        // Stalls, then asynchronous reset mid-stream.
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 0, '0, 1, 1);
        @(negedge clk);
        #3 reset = 1;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        reset = 0;
        clear_model();
        for (int i = 0; i < 6; i++) step(1, 0, '0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
